// File: rtl/fifo_burst_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_burst_reader: pops a counted burst from a sync FIFO onto a stream.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state;
  state_t                  state_next;
  logic [LEN_WIDTH-1:0]    remaining;
  logic                    inflight;
  logic                    inflight_last;
  logic [DATA_WIDTH-1:0]   buf_data [0:1];
  logic [1:0]              buf_last;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              occ;
  logic                    pop;
  logic                    issue;
  logic [2:0]              pending;

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_data[rd_ptr];
  assign m_last  = buf_last[rd_ptr];
  assign pop     = m_valid && m_ready;

  // Words that will still occupy the buffer after this cycle's pop, counting
  // the one returning from the FIFO; a new read is only allowed if it fits.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    state_next = state;
    issue      = (state == RUN) && !fifo_empty && (remaining != LEN_ZERO) &&
                 (pending < 3'd2);
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (burst_len == LEN_ZERO) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue && (remaining == LEN_ONE)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as soon as the last buffered beat is being accepted.
        if (!inflight && (occ == {1'b0, pop})) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign fifo_cs    = busy;
  assign fifo_rd_en = issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      occ           <= 2'd0;
      buf_last      <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
      end
    end else begin
      state <= state_next;

      if ((state == IDLE) && start) begin
        remaining <= burst_len;
      end else if (issue) begin
        remaining <= remaining - LEN_ONE;
      end

      inflight      <= issue;
      inflight_last <= issue && (remaining == LEN_ONE);

      if (inflight) begin
        buf_data[wr_ptr] <= fifo_data_out;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// Testbench for fifo_burst_reader: behavioural FIFO, queue-based expected stream.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          busy;
  logic          done;
  logic          fifo_cs;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_cs(fifo_cs), .fifo_rd_en(fifo_rd_en),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] fq[$];      // contents of the modelled FIFO
  logic [DW-1:0] exp_q[$];   // words still expected on the stream, in order
  logic [DW-1:0] late_q[$];  // words written into the FIFO during a burst
  int pops = 0, accepts = 0, cyc = 0;
  int beats = 0, cur_len = 0, done_cnt = 0, done_cyc = -1, last_hs = -1;
  int rmode = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    fq.push_back(v);
    exp_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // Synchronous FIFO read port: data appears the cycle after rd_en.
  initial begin
    fifo_data_out = '0;
    fifo_empty    = 1'b1;
  end
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_data_out <= fq.pop_front();
      pops++;
    end
    fifo_empty <= (fq.size() == 0);
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      check("rd_en_while_empty", 64'(fifo_rd_en && fifo_empty), 0);
      check("occupancy_le_2", 64'((pops - accepts) <= 2), 1);
      check("cs_follows_busy", 64'(fifo_cs), 64'(busy));
      if (m_valid) begin
        check("beat_within_burst", 64'(beats < cur_len), 1);
        if (exp_q.size() == 0) begin
          check("expected_word_available", 0, 1);
        end else begin
          check("m_data", m_data, exp_q[0]);
        end
        check("m_last", 64'(m_last), 64'(beats == cur_len - 1));
        if (m_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          beats++;
          accepts++;
          last_hs = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run_burst(input int len, input int gap, input bit restart);
    int start_cyc, pops0, gcnt;
    beats = 0; cur_len = len; done_cnt = 0; done_cyc = -1; last_hs = -1;
    pops0 = pops;
    @(posedge clk); #1;
    start = 1'b1;
    burst_len = len[LW-1:0];
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 1);
    gcnt = 0;
    for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
      if (late_q.size() > 0) begin
        gcnt++;
        if (gcnt >= gap) begin
          push_word(late_q.pop_front());
          gcnt = 0;
        end
      end
      if (restart && k == 2) begin
        start = 1'b1;
        burst_len = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("done_within_budget", 64'(done_cnt > 0), 1);
    repeat (2) @(posedge clk);
    #1;
    check("done_single_pulse", 64'(done_cnt), 1);
    check("beats_out", 64'(beats), 64'(len));
    check("fifo_reads", 64'(pops - pops0), 64'(len));
    check("done_timing", 64'(done_cyc), (len == 0) ? 64'(start_cyc + 1) : 64'(last_hs + 1));
    check("busy_after_done", 64'(busy), 0);
  endtask

  initial begin
    int len, pre;
    rst_n = 1'b0; start = 1'b0; burst_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_cs", 64'(fifo_cs), 0);
    check("rst_rd_en", 64'(fifo_rd_en), 0);
    check("rst_m_valid", 64'(m_valid), 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", 64'(m_last), 0);
    rst_n = 1'b1;

    // Preloaded burst with full throughput.
    rmode = 0;
    push_word(1); push_word(10); push_word(100);
    run_burst(3, 1, 1'b0);

    // Powers of two with alternating backpressure.
    rmode = 1;
    for (int i = 0; i < 8; i++) push_word(DW'(1) << i);
    run_burst(8, 1, 1'b0);

    // FIFO starts empty, words trickle in every third cycle.
    rmode = 0;
    late_q = '{32'd5, 32'd6, 32'd7, 32'd8};
    run_burst(4, 3, 1'b0);

    // Zero-length burst.
    run_burst(0, 1, 1'b0);

    // Second start during a burst must be ignored.
    for (int i = 0; i < 8; i++) push_word(32'h1000 + i);
    run_burst(8, 1, 1'b1);

    // Burst shorter than the FIFO contents leaves the remainder untouched.
    for (int i = 0; i < 9; i++) push_word(32'd200 + i);
    run_burst(8, 1, 1'b0);
    check("fifo_words_left", 64'(fq.size()), 1);
    if (fq.size() > 0) check("fifo_left_word", fq[0], 32'd208);
    fq.delete(); exp_q.delete(); fifo_empty = 1'b1;

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 10; i++) push_word($urandom);
    beats = 0; cur_len = 10;
    @(posedge clk); #1;
    start = 1'b1; burst_len = 8'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 0);
    check("midrst_done", 64'(done), 0);
    check("midrst_cs", 64'(fifo_cs), 0);
    check("midrst_rd_en", 64'(fifo_rd_en), 0);
    check("midrst_m_valid", 64'(m_valid), 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_m_last", 64'(m_last), 0);
    @(posedge clk); #1;
    fq.delete(); exp_q.delete(); fifo_empty = 1'b1;
    pops = 0; accepts = 0;
    rst_n = 1'b1;

    // Randomized bursts: mixed preload, trickle rate and backpressure.
    for (int t = 0; t < 12; t++) begin
      len   = $urandom_range(1, 20);
      pre   = $urandom_range(0, len);
      rmode = $urandom_range(0, 2);
      for (int i = 0; i < pre; i++) push_word($urandom);
      for (int i = pre; i < len; i++) late_q.push_back($urandom);
      run_burst(len, $urandom_range(1, 4), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
